etcpu_mem_resp: RTL and testbench
=================================

Name: etcpu_mem_resp

Overview:
- Responder side of the etcpu memory interfaces. Serves the core's main-memory port (cs/wen/addr/dat_in/dat_out) and its instruction-memory read port from internal word arrays.
- Adds a valid/ready loader port that fills instruction memory after reset, and holds the core in reset (cpu_rst_n low) until loading completes.
- Keeps access counters and a sticky access-error flag.
- Sits beside etcpu_top in the SoC/bench top.

Parameters:
- INST_MEM_DEPTH, 256, instruction memory depth in 32-bit words (power of 2).
- DATA_MEM_DEPTH, 256, data memory depth in 32-bit words (power of 2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cpu_rst_n  out  1  active-low reset driven to the core; low while not in RUN
- main_mem_cs  in  1  data access chip-select
- main_mem_wen  in  1  1 = write, 0 = read (qualified by cs)
- main_mem_addr  in  32  byte address
- main_mem_dat_in  in  32  write data
- main_mem_dat_out  out  32  read data
- inst_mem_addr  in  32  instruction byte address
- inst_mem_dat_out  out  32  instruction word
- ld_valid  in  1  loader word valid
- ld_ready  out  1  loader word accepted when valid & ready
- ld_data  in  32  instruction word to load
- ld_last  in  1  marks final loader word
- reload  in  1  single-cycle pulse: re-enter LOAD
- rd_cnt  out  32  completed data reads
- wr_cnt  out  32  completed data writes
- acc_err  out  1  sticky error flag

Behaviour:
- Reset (async, rst=1): state=LOAD, ld_ptr=0, rd_cnt=0, wr_cnt=0, acc_err=0, cpu_rst_n=0, ld_ready=0 while rst is high. Memory arrays are not reset.
- FSM states are LOAD and RUN.
- LOAD:
  - ld_ready=1 and cpu_rst_n=0.
  - On each handshake: write inst_mem[ld_ptr] <= ld_data, then ld_ptr++.
  - Go to RUN on the handshake where ld_last=1 or ld_ptr==INST_MEM_DEPTH-1. That word is still written. ld_ptr does not wrap.
  - main_mem_cs is ignored; no writes, no counting.
- RUN:
  - ld_ready=0 and ld_valid is ignored.
  - cpu_rst_n=1 starting the cycle after the LOAD->RUN transition (registered output).
- reload pulse (either state):
  - Next cycle: state=LOAD, ld_ptr=0, cpu_rst_n=0, acc_err=0. Counters hold their values.
  - If reload coincides with a loader handshake, that word is written and reload wins (ld_ptr=0, remain in LOAD).
- Instruction read: inst_mem_dat_out = inst_mem[inst_mem_addr[log2(INST_MEM_DEPTH)+1:2]], combinational, zero latency. Upper address bits and bits [1:0] are ignored. Valid in any state.
- Data read (cs=1, wen=0, RUN):
  - main_mem_dat_out = data_mem[word index], combinational, same cycle, as the core's memory-access stage consumes it.
  - If the access is invalid (see below), the output is 32'h0.
  - When cs=0, the output is 32'h0.
- Data write (cs=1, wen=1, RUN): data_mem[word index] <= main_mem_dat_in at the clock edge. Suppressed if the access is invalid.
- Read-during-write to the same address cannot occur: there is a single port and wen selects one operation.
- Invalid access: cs=1 in RUN with addr[1:0]!=0 or addr >= 4*DATA_MEM_DEPTH. acc_err <= 1 (sticky until rst or reload). Nothing is written; reads return 0. An invalid access is not counted.
- Counters: rd_cnt/wr_cnt increment by 1 per valid read/write cycle in RUN and saturate at 32'hFFFF_FFFF (no wrap).
- Back-to-back accesses are supported every cycle; there are no wait states.
- Reset asserted mid-load or mid-run: immediate return to reset values. Array contents are retained.

Test Plan:
- Reset, then load 3 words (0x00000013, 0x00100093, 0x00200113) with ld_last on the third: ld_ready=1 throughout, cpu_rst_n rises 1 cycle after the 3rd handshake, and inst_mem_addr=0x4 reads 0x00100093.
- Loader ld_valid toggling with gaps, 256 words and no ld_last: exactly 256 words are written, transition to RUN after word 255, ld_ready drops, and a further ld_valid has no effect.
- RUN: write 0xDEADBEEF to addr 0x10, then read addr 0x10 the next cycle: dat_out=0xDEADBEEF in the same cycle as cs, wr_cnt=1, rd_cnt=1.
- Invalid accesses: write to 0x12 (misaligned), then read 0x400 (DEPTH=256): acc_err=1, read data=0, location 0x10 unchanged, counters unchanged.
- reload pulse in RUN with acc_err=1: next cycle cpu_rst_n=0, ld_ready=1, acc_err=0, counters held. Reload 1 word with ld_last: the word lands at addr 0.
- Assert rst asynchronously mid-load (after 2 of 4 words): outputs reset immediately without a clock edge. Reload from ld_ptr=0; the first two words previously loaded are still readable before being overwritten.

Source files
------------

// File: rtl/etcpu_mem_resp.sv
// etcpu memory responder: serves the core's data and instruction ports from
// internal word arrays. It also provides a valid/ready loader that fills
// instruction memory after reset and keeps the core in reset until loading
// completes. It counts completed data accesses and keeps a sticky error flag.
module etcpu_mem_resp #(
  parameter int INST_MEM_DEPTH = 256,
  parameter int DATA_MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic        cpu_rst_n,
  input  logic        main_mem_cs,
  input  logic        main_mem_wen,
  input  logic [31:0] main_mem_addr,
  input  logic [31:0] main_mem_dat_in,
  output logic [31:0] main_mem_dat_out,
  input  logic [31:0] inst_mem_addr,
  output logic [31:0] inst_mem_dat_out,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  input  logic        reload,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic        acc_err
);

  localparam int IW = $clog2(INST_MEM_DEPTH);
  localparam int DW = $clog2(DATA_MEM_DEPTH);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [IW-1:0] LD_PTR_MAX = IW'(INST_MEM_DEPTH - 1);
  localparam logic [31:0]   CNT_MAX    = 32'hFFFF_FFFF;

  logic [31:0] inst_mem [INST_MEM_DEPTH];
  logic [31:0] data_mem [DATA_MEM_DEPTH];

  logic [0:0]    state_q,     state_d;
  logic [IW-1:0] ld_ptr_q,    ld_ptr_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;
  logic          ld_ready_q,  ld_ready_d;
  logic [31:0]   rd_cnt_q,    rd_cnt_d;
  logic [31:0]   wr_cnt_q,    wr_cnt_d;
  logic          acc_err_q,   acc_err_d;

  logic          run_s;
  logic          ld_hs_s;
  logic          acc_s;
  logic          addr_ok_s;
  logic          rd_ok_s;
  logic          wr_ok_s;
  logic          bad_s;
  logic [DW-1:0] d_idx_s;
  logic [IW-1:0] i_idx_s;
  logic          unused_addr_s;

  assign run_s   = (state_q == ST_RUN);
  // ld_ready_q is only high in LOAD, but qualify with state for clarity.
  assign ld_hs_s = ld_valid & ld_ready_q & (state_q == ST_LOAD);
  // Data port accesses only matter once the core is running.
  assign acc_s   = run_s & main_mem_cs;

  // A data access is legal when word aligned and inside the data array.
  assign addr_ok_s = (main_mem_addr[1:0] == 2'b00) &&
                     ((main_mem_addr >> (DW + 2)) == 32'd0);

  assign rd_ok_s = acc_s & ~main_mem_wen & addr_ok_s;
  assign wr_ok_s = acc_s &  main_mem_wen & addr_ok_s;
  assign bad_s   = acc_s & ~addr_ok_s;

  assign d_idx_s = main_mem_addr[DW+1:2];
  assign i_idx_s = inst_mem_addr[IW+1:2];

  // Instruction fetch ignores byte offset and out-of-range upper bits.
  assign unused_addr_s = ^{inst_mem_addr[31:IW+2], inst_mem_addr[1:0]};

  // Next-state logic for the LOAD/RUN sequencer and the loader pointer.
  always_comb begin
    state_d  = state_q;
    ld_ptr_d = ld_ptr_q;
    case (state_q)
      ST_LOAD: begin
        if (ld_hs_s) begin
          if (ld_last || (ld_ptr_q == LD_PTR_MAX)) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_LOAD;
          end
          // The pointer saturates at the last slot instead of wrapping.
          if (ld_ptr_q != LD_PTR_MAX) begin
            ld_ptr_d = ld_ptr_q + IW'(1);
          end else begin
            ld_ptr_d = ld_ptr_q;
          end
        end else begin
          state_d  = ST_LOAD;
          ld_ptr_d = ld_ptr_q;
        end
      end
      ST_RUN: begin
        state_d  = ST_RUN;
        ld_ptr_d = ld_ptr_q;
      end
      default: begin
        state_d  = ST_LOAD;
        ld_ptr_d = '0;
      end
    endcase
    // A reload pulse overrides everything, including a coincident handshake.
    if (reload) begin
      state_d  = ST_LOAD;
      ld_ptr_d = '0;
    end else begin
      state_d  = state_d;
      ld_ptr_d = ld_ptr_d;
    end
  end

  // Registered handshake / core-reset outputs follow the next state.
  always_comb begin
    cpu_rst_n_d = (state_d == ST_RUN);
    ld_ready_d  = (state_d == ST_LOAD);
  end

  // Sticky error flag and saturating access counters.
  always_comb begin
    acc_err_d = acc_err_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    if (reload) begin
      acc_err_d = 1'b0;
    end else if (bad_s) begin
      acc_err_d = 1'b1;
    end else begin
      acc_err_d = acc_err_q;
    end
    if (rd_ok_s && (rd_cnt_q != CNT_MAX)) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
    if (wr_ok_s && (wr_cnt_q != CNT_MAX)) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
  end

  // Control and status registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      ld_ptr_q    <= '0;
      cpu_rst_n_q <= 1'b0;
      ld_ready_q  <= 1'b0;
      rd_cnt_q    <= 32'd0;
      wr_cnt_q    <= 32'd0;
      acc_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_ptr_q    <= ld_ptr_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      ld_ready_q  <= ld_ready_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      acc_err_q   <= acc_err_d;
    end
  end

  // Instruction memory write port, fed only by the loader (no reset).
  always_ff @(posedge clk) begin
    if (ld_hs_s) begin
      inst_mem[ld_ptr_q] <= ld_data;
    end
  end

  // Data memory write port, fed only by valid core writes (no reset).
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      data_mem[d_idx_s] <= main_mem_dat_in;
    end
  end

  // Zero-latency read paths consumed by the core in the same cycle.
  always_comb begin
    inst_mem_dat_out = inst_mem[i_idx_s];
    if (rd_ok_s) begin
      main_mem_dat_out = data_mem[d_idx_s];
    end else begin
      main_mem_dat_out = 32'h0000_0000;
    end
  end

  assign cpu_rst_n = cpu_rst_n_q;
  assign ld_ready  = ld_ready_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign acc_err   = acc_err_q;

endmodule

// File: tb/tb_etcpu_mem_resp.sv
// Directed scoreboard bench for etcpu_mem_resp.
module tb_etcpu_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_rst_n;
  logic        main_mem_cs = 1'b0;
  logic        main_mem_wen = 1'b0;
  logic [31:0] main_mem_addr = 32'd0;
  logic [31:0] main_mem_dat_in = 32'd0;
  logic [31:0] main_mem_dat_out;
  logic [31:0] inst_mem_addr = 32'd0;
  logic [31:0] inst_mem_dat_out;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_data = 32'd0;
  logic        ld_last = 1'b0;
  logic        reload = 1'b0;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic        acc_err;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q [$];
  logic [31:0] imem_m [256];
  int m_ptr = 0;

  etcpu_mem_resp #(.INST_MEM_DEPTH(256), .DATA_MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .cpu_rst_n(cpu_rst_n),
    .main_mem_cs(main_mem_cs), .main_mem_wen(main_mem_wen),
    .main_mem_addr(main_mem_addr), .main_mem_dat_in(main_mem_dat_in),
    .main_mem_dat_out(main_mem_dat_out),
    .inst_mem_addr(inst_mem_addr), .inst_mem_dat_out(inst_mem_dat_out),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_last(ld_last), .reload(reload),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .acc_err(acc_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic imem_chk(input string tag, input logic [31:0] a);
    inst_mem_addr = a;
    exp_q.push_back(imem_m[a[9:2]]);
    #1;
    check(tag, inst_mem_dat_out, exp_q.pop_front());
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    check("ld_ready_in_load", 32'(ld_ready), 32'd1);
    check("cpu_rst_n_in_load", 32'(cpu_rst_n), 32'd0);
    imem_m[m_ptr] = d;
    m_ptr++;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d);
    main_mem_cs = 1'b1;
    main_mem_wen = 1'b1;
    main_mem_addr = a;
    main_mem_dat_in = d;
    exp_q.push_back(32'd0);
    #1;
    check("dout_on_write", main_mem_dat_out, exp_q.pop_front());
    step();
    main_mem_cs = 1'b0;
    main_mem_wen = 1'b0;
  endtask

  task automatic mem_read(input string tag, input logic [31:0] a, input logic [31:0] e);
    main_mem_cs = 1'b1;
    main_mem_wen = 1'b0;
    main_mem_addr = a;
    exp_q.push_back(e);
    #1;
    check(tag, main_mem_dat_out, exp_q.pop_front());
    step();
    main_mem_cs = 1'b0;
  endtask

  initial begin
    // Reset values while rst is high
    #3;
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_rd_cnt", rd_cnt, 32'd0);
    check("rst_wr_cnt", wr_cnt, 32'd0);
    check("rst_acc_err", 32'(acc_err), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("ld_ready_after_rst", 32'(ld_ready), 32'd1);

    // Three-word program with ld_last on the third
    m_ptr = 0;
    load_word(32'h0000_0013, 1'b0);
    load_word(32'h0010_0093, 1'b0);
    load_word(32'h0020_0113, 1'b1);
    check("cpu_rst_n_run", 32'(cpu_rst_n), 32'd1);
    check("ld_ready_run", 32'(ld_ready), 32'd0);
    imem_chk("imem_4", 32'h0000_0004);
    step();

    // Valid data accesses
    mem_write(32'h0000_0010, 32'hDEAD_BEEF);
    check("wr_cnt_1", wr_cnt, 32'd1);
    mem_read("rd_0x10", 32'h0000_0010, 32'hDEAD_BEEF);
    check("rd_cnt_1", rd_cnt, 32'd1);
    mem_write(32'h0000_0000, 32'hCAFE_F00D);
    check("wr_cnt_2", wr_cnt, 32'd2);
    main_mem_addr = 32'h0000_0010;
    exp_q.push_back(32'd0);
    #1;
    check("dout_cs0", main_mem_dat_out, exp_q.pop_front());
    step();

    // Invalid accesses
    mem_write(32'h0000_0012, 32'h1234_5678);
    check("acc_err_set", 32'(acc_err), 32'd1);
    mem_read("rd_oob", 32'h0000_0400, 32'd0);
    mem_read("rd_misalign", 32'h0000_0011, 32'd0);
    check("rd_cnt_inv", rd_cnt, 32'd1);
    check("wr_cnt_inv", wr_cnt, 32'd2);
    mem_read("rd_0x10_kept", 32'h0000_0010, 32'hDEAD_BEEF);
    mem_read("rd_0x0", 32'h0000_0000, 32'hCAFE_F00D);
    check("rd_cnt_3", rd_cnt, 32'd3);
    check("acc_err_sticky", 32'(acc_err), 32'd1);

    // Reload in RUN
    reload = 1'b1;
    step();
    reload = 1'b0;
    check("reload_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("reload_ld_ready", 32'(ld_ready), 32'd1);
    check("reload_acc_err", 32'(acc_err), 32'd0);
    check("reload_rd_cnt", rd_cnt, 32'd3);
    check("reload_wr_cnt", wr_cnt, 32'd2);
    m_ptr = 0;
    mem_write(32'h0000_0010, 32'h1111_1111);
    mem_write(32'h0000_0013, 32'h2222_2222);
    check("load_ignores_cs_wr", wr_cnt, 32'd2);
    check("load_ignores_cs_err", 32'(acc_err), 32'd0);
    load_word(32'h0BAD_C0DE, 1'b1);
    check("cpu_rst_n_run2", 32'(cpu_rst_n), 32'd1);
    imem_chk("imem_0_reload", 32'h0000_0000);
    imem_chk("imem_4_kept", 32'h0000_0004);
    step();
    mem_read("rd_0x10_after_load", 32'h0000_0010, 32'hDEAD_BEEF);
    check("rd_cnt_4", rd_cnt, 32'd4);

    // Full 256-word load with gaps and no ld_last
    reload = 1'b1;
    step();
    reload = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < 256; i++) begin
      if ((i % 3) == 0) begin
        step();
      end
      load_word(32'hA500_0000 | 32'(i), 1'b0);
    end
    check("full_ld_ready", 32'(ld_ready), 32'd0);
    check("full_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    ld_valid = 1'b1;
    ld_data = 32'hFFFF_FFFF;
    step();
    step();
    ld_valid = 1'b0;
    check("run_ld_ready", 32'(ld_ready), 32'd0);
    for (int i = 0; i < 256; i++) begin
      imem_chk("imem_full", 32'(i) << 2);
    end
    imem_chk("imem_alias", 32'h0000_0403);
    step();

    // Reload coinciding with a handshake
    reload = 1'b1;
    step();
    reload = 1'b0;
    m_ptr = 0;
    load_word(32'h5555_0000, 1'b0);
    ld_valid = 1'b1;
    ld_data = 32'h6666_0000;
    reload = 1'b1;
    imem_m[1] = 32'h6666_0000;
    step();
    ld_valid = 1'b0;
    reload = 1'b0;
    m_ptr = 0;
    check("reload_hs_ready", 32'(ld_ready), 32'd1);
    imem_chk("imem_reload_hs", 32'h0000_0004);

    // Asynchronous reset mid-load
    load_word(32'h1111_0000, 1'b0);
    load_word(32'h2222_0000, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_ld_ready", 32'(ld_ready), 32'd0);
    check("async_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("async_rd_cnt", rd_cnt, 32'd0);
    check("async_wr_cnt", wr_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ptr = 0;
    imem_chk("retain_0", 32'h0000_0000);
    imem_chk("retain_4", 32'h0000_0004);
    imem_chk("retain_8", 32'h0000_0008);
    step();
    check("post_rst_ready", 32'(ld_ready), 32'd1);
    load_word(32'h3333_0000, 1'b0);
    load_word(32'h3333_0001, 1'b0);
    load_word(32'h3333_0002, 1'b0);
    load_word(32'h3333_0003, 1'b1);
    check("final_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    imem_chk("final_0", 32'h0000_0000);
    imem_chk("final_4", 32'h0000_0004);
    imem_chk("final_8", 32'h0000_0008);
    imem_chk("final_c", 32'h0000_000C);
    imem_chk("final_10", 32'h0000_0010);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
